// File: rtl/img_get_grads_mul_pipe_if.sv
// Sample-side bus of the gradient multiplier: clock enable, input sample
// with its valid and sign mode, and the registered result with overflow flag.
interface img_get_grads_mul_pipe_if #(
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 13,
  parameter int dout_WIDTH = 26
);
  logic                  ce;
  logic                  vld_in;
  logic                  sgn;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  vld_out;
  logic [dout_WIDTH-1:0] dout;
  logic                  ovf;

  modport master (
    output ce, vld_in, sgn, din0, din1,
    input  vld_out, dout, ovf
  );

  modport slave (
    input  ce, vld_in, sgn, din0, din1,
    output vld_out, dout, ovf
  );
endinterface

// File: rtl/img_get_grads_mul_pipe.sv
// Pipelined signed/unsigned multiplier for the img_get_grads datapath.
// Operand register, NUM_STAGE-2 product registers and a result register
// holding the shifted and saturated product; everything stalls on ce=0.
module img_get_grads_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 13,
  parameter int dout_WIDTH = 26,
  parameter int SHIFT      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  img_get_grads_mul_pipe_if.slave bus
);

  // ID tags the instance and never alters behaviour.
  localparam int DEPTH = NUM_STAGE + (ID - ID);

  // Full product plus one bit so that unsigned and signed products share
  // one signed container without loss.
  localparam int P   = din0_WIDTH + din1_WIDTH;
  localparam int PW  = P + 1;
  localparam int CW  = (PW > dout_WIDTH + 1) ? PW : dout_WIDTH + 1;
  localparam int MID = (DEPTH > 2) ? DEPTH - 2 : 0;

  localparam logic signed [CW-1:0] UMAX =
    {{(CW - dout_WIDTH){1'b0}}, {dout_WIDTH{1'b1}}};
  localparam logic signed [CW-1:0] SMAX =
    {{(CW - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
  localparam logic signed [CW-1:0] SMIN =
    {{(CW - dout_WIDTH + 1){1'b1}}, {(dout_WIDTH - 1){1'b0}}};

  logic [din0_WIDTH-1:0] mul_a;
  logic [din1_WIDTH-1:0] mul_b;
  logic                  mul_sgn;
  logic                  mul_vld;

  logic signed [PW-1:0]  ext_a;
  logic signed [PW-1:0]  ext_b;
  logic signed [PW-1:0]  prod;

  logic signed [PW-1:0]  sat_in;
  logic                  sat_sgn;
  logic                  sat_vld;

  logic signed [PW-1:0]  shifted;
  logic signed [CW-1:0]  wide;
  logic [dout_WIDTH-1:0] dout_d;
  logic                  ovf_d;

  logic [dout_WIDTH-1:0] dout_q;
  logic                  ovf_q;
  logic                  vld_q;

  generate
    if (DEPTH >= 2) begin : g_in_reg
      logic [din0_WIDTH-1:0] a_q;
      logic [din1_WIDTH-1:0] b_q;
      logic                  sgn_q;
      logic                  vld_in_q;

      // Stage 1: capture operands, sign mode and valid.
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge value of its source, independent of block order.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q      <= '0;
          b_q      <= '0;
          sgn_q    <= 1'b0;
          vld_in_q <= 1'b0;
        end else if (bus.ce) begin
          a_q      <= bus.din0;
          b_q      <= bus.din1;
          sgn_q    <= bus.sgn;
          vld_in_q <= bus.vld_in;
        end
      end

      assign mul_a   = a_q;
      assign mul_b   = b_q;
      assign mul_sgn = sgn_q;
      assign mul_vld = vld_in_q;
    end else begin : g_in_comb
      assign mul_a   = bus.din0;
      assign mul_b   = bus.din1;
      assign mul_sgn = bus.sgn;
      assign mul_vld = bus.vld_in;
    end
  endgenerate

  // Exact product: extend each operand per sample mode, multiply at full width.
  always_comb begin
    ext_a = {{(PW - din0_WIDTH){mul_sgn & mul_a[din0_WIDTH-1]}}, mul_a};
    ext_b = {{(PW - din1_WIDTH){mul_sgn & mul_b[din1_WIDTH-1]}}, mul_b};
    prod  = ext_a * ext_b;
  end

  generate
    if (MID > 0) begin : g_mid
      logic signed [PW-1:0] prod_q [MID];
      logic                 sgn_q  [MID];
      logic                 vld_q  [MID];

      // Product stages (DSP M/P registers); sign mode and valid ride along.
      // NOTE: data registers are reset along with the valid bits so the outputs
      // are deterministic from reset onward, not only when vld_out is high.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < MID; i++) begin
            prod_q[i] <= '0;
            sgn_q[i]  <= 1'b0;
            vld_q[i]  <= 1'b0;
          end
        end else if (bus.ce) begin
          prod_q[0] <= prod;
          sgn_q[0]  <= mul_sgn;
          vld_q[0]  <= mul_vld;
          for (int i = 1; i < MID; i++) begin
            prod_q[i] <= prod_q[i-1];
            sgn_q[i]  <= sgn_q[i-1];
            vld_q[i]  <= vld_q[i-1];
          end
        end
      end

      assign sat_in  = prod_q[MID-1];
      assign sat_sgn = sgn_q[MID-1];
      assign sat_vld = vld_q[MID-1];
    end else begin : g_no_mid
      assign sat_in  = prod;
      assign sat_sgn = mul_sgn;
      assign sat_vld = mul_vld;
    end
  endgenerate

  // Shift (arithmetic; unsigned products are non-negative here so this is
  // also the logical shift) and clamp to the result range of the sample mode.
  // NOTE: every output of this block is assigned before any condition, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    shifted = sat_in >>> SHIFT;
    wide    = CW'(shifted);
    dout_d  = wide[dout_WIDTH-1:0];
    ovf_d   = 1'b0;
    if (sat_sgn) begin
      if (wide > SMAX) begin
        dout_d = SMAX[dout_WIDTH-1:0];
        ovf_d  = 1'b1;
      end else if (wide < SMIN) begin
        dout_d = SMIN[dout_WIDTH-1:0];
        ovf_d  = 1'b1;
      end
    end else if (wide > UMAX) begin
      dout_d = UMAX[dout_WIDTH-1:0];
      ovf_d  = 1'b1;
    end
  end

  // Final stage: registered result, overflow flag and valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else if (bus.ce) begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      vld_q  <= sat_vld;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.ovf     = ovf_q;
  assign bus.vld_out = vld_q;

endmodule

// File: tb/tb_img_get_grads_mul_pipe.sv
// Bench for img_get_grads_mul_pipe: five instances (default, saturating,
// depth 1, 2, 6) share one stimulus stream. Directed vectors carry
// hand-computed results; a delay-line reference checks every instance.
module tb_img_get_grads_mul_pipe;

  localparam int NDUT = 5;
  localparam int NS_A [NDUT] = '{3, 3, 1, 2, 6};
  localparam int DW_A [NDUT] = '{26, 16, 26, 26, 26};
  localparam int SH_A [NDUT] = '{0, 4, 0, 0, 0};

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        vld_in;
  logic        sgn;
  logic [12:0] din0;
  logic [12:0] din1;

  logic        obs_v [NDUT];
  logic        obs_o [NDUT];
  logic [31:0] obs_d [NDUT];

  // Reference delay lines, one slot per enabled edge.
  logic        m_v [NDUT][6];
  logic        m_o [NDUT][6];
  logic [31:0] m_d [NDUT][6];

  int total = 0;
  int bad   = 0;
  int n_out0;
  logic [31:0] hold_d;
  logic        hold_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    img_get_grads_mul_pipe_if #(.din0_WIDTH(13), .din1_WIDTH(13),
                                .dout_WIDTH(DW_A[g])) bus ();
    assign bus.ce     = ce;
    assign bus.vld_in = vld_in;
    assign bus.sgn    = sgn;
    assign bus.din0   = din0;
    assign bus.din1   = din1;
    img_get_grads_mul_pipe #(
      .ID(g), .NUM_STAGE(NS_A[g]), .din0_WIDTH(13), .din1_WIDTH(13),
      .dout_WIDTH(DW_A[g]), .SHIFT(SH_A[g])
    ) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
    );
    assign obs_v[g] = bus.vld_out;
    assign obs_o[g] = bus.ovf;
    assign obs_d[g] = 32'(bus.dout);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Integer model: exact product, floor shift, clamp to the result range.
  function automatic void ref_mul(input logic s, input logic [12:0] a, input logic [12:0] b,
                                  input int dw, input int sh,
                                  output logic [31:0] d, output logic o);
    longint pa, pb, p, mx, mn;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    p  = (pa * pb) >>> sh;
    if (s) begin
      mx = (longint'(1) <<< (dw - 1)) - 1;
      mn = -(longint'(1) <<< (dw - 1));
    end else begin
      mx = (longint'(1) << dw) - 1;
      mn = 0;
    end
    o = 1'b0;
    if (p > mx) begin
      p = mx;
      o = 1'b1;
    end else if (p < mn) begin
      p = mn;
      o = 1'b1;
    end
    d = 32'(p & ((longint'(1) << dw) - 1));
  endfunction

  task automatic model_clear();
    for (int d = 0; d < NDUT; d++)
      for (int j = 0; j < 6; j++) begin
        m_v[d][j] = 1'b0;
        m_o[d][j] = 1'b0;
        m_d[d][j] = '0;
      end
  endtask

  task automatic model_edge();
    logic [31:0] rd;
    logic        ro;
    if (!reset && ce) begin
      for (int d = 0; d < NDUT; d++) begin
        for (int j = 5; j > 0; j--) begin
          m_v[d][j] = m_v[d][j-1];
          m_o[d][j] = m_o[d][j-1];
          m_d[d][j] = m_d[d][j-1];
        end
        ref_mul(sgn, din0, din1, DW_A[d], SH_A[d], rd, ro);
        m_v[d][0] = vld_in;
        m_o[d][0] = ro;
        m_d[d][0] = rd;
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("vld_out[%0d]", d), 32'(obs_v[d]), 32'(m_v[d][NS_A[d]-1]));
      if (m_v[d][NS_A[d]-1]) begin
        chk($sformatf("dout[%0d]", d), obs_d[d], m_d[d][NS_A[d]-1]);
        chk($sformatf("ovf[%0d]", d), 32'(obs_o[d]), 32'(m_o[d][NS_A[d]-1]));
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cyc(input logic c, input logic v, input logic s,
                     input logic [12:0] a, input logic [12:0] b);
    ce = c; vld_in = v; sgn = s; din0 = a; din1 = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (c && obs_v[0]) n_out0++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 13'h0, 13'h0);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; vld_in = 1'b0; sgn = 1'b0; din0 = '0; din1 = '0;
    n_out0 = 0;
    model_clear();
    repeat (2) @(negedge clk);

    // Reset state.
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_vld[%0d]", d), 32'(obs_v[d]), 32'd0);
      chk($sformatf("rst_dout[%0d]", d), obs_d[d], 32'd0);
      chk($sformatf("rst_ovf[%0d]", d), 32'(obs_o[d]), 32'd0);
    end
    reset = 1'b0;
    idle(2);

    // Unsigned baseline.
    cyc(1'b1, 1'b1, 1'b0, 13'd8191, 13'd8191);
    chk("ubase_d1_dout", obs_d[2], 32'd67092481);
    cyc(1'b1, 1'b1, 1'b0, 13'd0, 13'd8191);
    chk("ubase_early_vld", 32'(obs_v[0]), 32'd0);
    idle(1);
    chk("ubase_vld", 32'(obs_v[0]), 32'd1);
    chk("ubase_max", obs_d[0], 32'd67092481);
    chk("ubase_ovf", 32'(obs_o[0]), 32'd0);
    idle(1);
    chk("ubase_zero", obs_d[0], 32'd0);
    idle(4);

    // Signed then unsigned, back-to-back.
    cyc(1'b1, 1'b1, 1'b1, 13'h1FFF, 13'd5);
    cyc(1'b1, 1'b1, 1'b0, 13'h1FFF, 13'd5);
    idle(1);
    chk("mix_s_vld", 32'(obs_v[0]), 32'd1);
    chk("mix_s_dout", obs_d[0], 32'h3FF_FFFB);
    idle(1);
    chk("mix_u_vld", 32'(obs_v[0]), 32'd1);
    chk("mix_u_dout", obs_d[0], 32'd40955);
    idle(4);

    // Saturation on the 16-bit, shift-4 instance.
    cyc(1'b1, 1'b1, 1'b0, 13'd4095, 13'd4095);
    cyc(1'b1, 1'b1, 1'b1, 13'h1000, 13'd4095);
    cyc(1'b1, 1'b1, 1'b1, 13'd100, 13'h1FFD);
    chk("sat_u_dout", obs_d[1], 32'd65535);
    chk("sat_u_ovf", 32'(obs_o[1]), 32'd1);
    idle(1);
    chk("sat_smin_dout", obs_d[1], 32'h8000);
    chk("sat_smin_ovf", 32'(obs_o[1]), 32'd1);
    idle(1);
    chk("sat_s_dout", obs_d[1], 32'hFFED);
    chk("sat_s_ovf", 32'(obs_o[1]), 32'd0);
    idle(6);

    // Stall: 8 samples with a 5-cycle ce=0 gap in the middle.
    n_out0 = 0;
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 1'(i), 13'(100 + i * 37), 13'(8000 - i * 911));
    hold_d = obs_d[0];
    hold_v = obs_v[0];
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 13'h1ABC, 13'h0F0F);
      chk("stall_hold_vld", 32'(obs_v[0]), 32'(hold_v));
      chk("stall_hold_dout", obs_d[0], hold_d);
    end
    for (int i = 4; i < 8; i++)
      cyc(1'b1, 1'b1, 1'(i), 13'(100 + i * 37), 13'(8000 - i * 911));
    idle(8);
    chk("stall_count", 32'(n_out0), 32'd8);

    // Reset with three samples in flight.
    cyc(1'b1, 1'b1, 1'b0, 13'd11, 13'd13);
    cyc(1'b1, 1'b1, 1'b1, 13'h1F00, 13'd77);
    cyc(1'b1, 1'b1, 1'b0, 13'd4000, 13'd2);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("mid_rst_vld[%0d]", d), 32'(obs_v[d]), 32'd0);
      chk($sformatf("mid_rst_dout[%0d]", d), obs_d[d], 32'd0);
      chk($sformatf("mid_rst_ovf[%0d]", d), 32'(obs_o[d]), 32'd0);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 13'd3, 13'd7);
    idle(1);
    chk("post_rst_early", 32'(obs_v[0]), 32'd0);
    idle(1);
    chk("post_rst_vld", 32'(obs_v[0]), 32'd1);
    chk("post_rst_dout", obs_d[0], 32'd21);
    idle(6);

    // Random mixed-mode stream with random stalls across all depths.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
          13'($urandom), 13'($urandom));
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
